// File: rtl/id_ex_pkg.sv
// id_ex_pkg
//   Shared types and default widths for the ID/EX pipeline register.
//   - Default width localparams for the RV64 pipeline.
//   - ctrl_t    : decoded control bundle, MSB first {mem_to_reg .. alu_op}.
//   - payload_t : full ID->EX payload at default widths; the bit order matches
//                 the concatenation used inside id_ex_pipe_reg.
//   - skid_state_t : EMPTY / ONE / FULL occupancy of the skid buffer.
package id_ex_pkg;

    localparam int XLEN_DEF       = 64;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int FUNCT_W_DEF    = 4;
    localparam int ALUOP_W_DEF    = 2;
    localparam int CNT_W_DEF      = 32;

    typedef struct packed {
        logic                   mem_to_reg;
        logic                   reg_write;
        logic                   branch;
        logic                   mem_write;
        logic                   mem_read;
        logic                   alu_src;
        logic [ALUOP_W_DEF-1:0] alu_op;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN_DEF-1:0]       pc;
        logic [XLEN_DEF-1:0]       rs1_data;
        logic [XLEN_DEF-1:0]       rs2_data;
        logic [XLEN_DEF-1:0]       imm;
        logic [FUNCT_W_DEF-1:0]    funct;
        logic [REG_ADDR_W_DEF-1:0] rd;
        logic [REG_ADDR_W_DEF-1:0] rs1;
        logic [REG_ADDR_W_DEF-1:0] rs2;
        ctrl_t                     ctrl;
    } payload_t;

    localparam int PAYLOAD_W_DEF = $bits(payload_t);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf
//   Generic 2-entry skid buffer: main entry M drives the output, skid entry S
//   catches the one payload that arrives while the consumer stalls.
//   Ports:
//     clk, reset (sync, active-high), flush (sync kill of all entries)
//     in_valid / in_ready / in_data    : producer side
//     out_valid / out_ready / out_data : consumer side (out_data = M)
//     state                            : current occupancy, for debug/checkers
//
//   Handshake: a transfer happens on a rising edge where valid && ready are
//   both high on that interface. in_ready is a flop computed from the next
//   state, so it never depends combinationally on out_ready. Once in_valid is
//   raised the producer is expected to hold its payload until accepted.
module pipe_skid_buf
    import id_ex_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output skid_state_t       state
);

    skid_state_t       state_nxt;
    logic [DATA_W-1:0] m_data, m_nxt;
    logic [DATA_W-1:0] s_data, s_nxt;
    logic              accept, drain;

    assign out_valid = (state != ST_EMPTY);
    assign out_data  = m_data;
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    // Reset and flush both return to an empty, zeroed buffer; an accept in
    // the same cycle is dropped, a drain has already been seen by the consumer.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state    <= ST_EMPTY;
            m_data   <= '0;
            s_data   <= '0;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            m_data   <= m_nxt;
            s_data   <= s_nxt;
            in_ready <= (state_nxt != ST_FULL);
        end
    end

    always_comb begin
        state_nxt = state;
        m_nxt     = m_data;
        s_nxt     = s_data;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_nxt = ST_ONE;
                    m_nxt     = in_data;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    m_nxt = in_data;
                end else if (accept) begin
                    state_nxt = ST_FULL;
                    s_nxt     = in_data;
                end else if (drain) begin
                    state_nxt = ST_EMPTY;
                    m_nxt     = '0;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only a drain can move the state.
                if (drain) begin
                    state_nxt = ST_ONE;
                    m_nxt     = s_data;
                    s_nxt     = '0;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
                m_nxt     = '0;
                s_nxt     = '0;
            end
        endcase
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg
//   ID/EX pipeline register with valid/ready handshake and a 2-entry skid
//   buffer. Payload is carried unmodified; while out_valid is low every out_*
//   field (including out_ctrl) is forced to zero so EX sees a clean bubble.
//   Ports:
//     clk, reset (sync, active-high), flush
//     in_valid, in_ready, in_pc, in_rs1_data, in_rs2_data, in_imm, in_funct,
//     in_rd, in_rs1, in_rs2, in_ctrl                     : from ID
//     out_valid, out_ready, out_* (same fields)          : to EX
//     stall_cnt, bubble_cnt, flush_cnt                   : only with
//                                      ID_EX_PERF_CNT_EN defined
//     dbg_state                                          : skid buffer state
//   Optional feature macro: ID_EX_PERF_CNT_EN (saturating performance counters).
module id_ex_pipe_reg
    import id_ex_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int FUNCT_W    = FUNCT_W_DEF,
    parameter int ALUOP_W    = ALUOP_W_DEF
`ifdef ID_EX_PERF_CNT_EN
    ,
    parameter int CNT_W      = CNT_W_DEF
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [XLEN-1:0]       in_rs1_data,
    input  logic [XLEN-1:0]       in_rs2_data,
    input  logic [XLEN-1:0]       in_imm,
    input  logic [FUNCT_W-1:0]    in_funct,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [REG_ADDR_W-1:0] in_rs1,
    input  logic [REG_ADDR_W-1:0] in_rs2,
    input  logic [6+ALUOP_W-1:0]  in_ctrl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_pc,
    output logic [XLEN-1:0]       out_rs1_data,
    output logic [XLEN-1:0]       out_rs2_data,
    output logic [XLEN-1:0]       out_imm,
    output logic [FUNCT_W-1:0]    out_funct,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [REG_ADDR_W-1:0] out_rs1,
    output logic [REG_ADDR_W-1:0] out_rs2,
    output logic [6+ALUOP_W-1:0]  out_ctrl,
`ifdef ID_EX_PERF_CNT_EN
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      bubble_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
`endif
    output skid_state_t           dbg_state
);

    localparam int DATA_W = 4*XLEN + FUNCT_W + 3*REG_ADDR_W + 6 + ALUOP_W;

    logic [DATA_W-1:0] in_bus, buf_bus, out_bus;
    logic              buf_valid;

    assign in_bus = {in_pc, in_rs1_data, in_rs2_data, in_imm, in_funct,
                     in_rd, in_rs1, in_rs2, in_ctrl};

    pipe_skid_buf #(.DATA_W(DATA_W)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_bus),
        .out_valid (buf_valid),
        .out_ready (out_ready),
        .out_data  (buf_bus),
        .state     (dbg_state)
    );

    // Bubble gating: the buffer already zeroes M when it empties, but gating
    // here guarantees control bits can never leak while the output is invalid.
    assign out_valid = buf_valid;
    assign out_bus   = buf_valid ? buf_bus : '0;
    assign {out_pc, out_rs1_data, out_rs2_data, out_imm, out_funct,
            out_rd, out_rs1, out_rs2, out_ctrl} = out_bus;

`ifdef ID_EX_PERF_CNT_EN
    // Saturating counters; only reset clears them, flush does not.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (buf_valid && !out_ready && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (!buf_valid && (bubble_cnt != '1))
                bubble_cnt <= bubble_cnt + 1'b1;
            if (flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
module tb_id_ex_pipe_reg;
    import id_ex_pkg::*;

    localparam int XW = 64;
    localparam int AW = 5;
    localparam int FW = 4;
    localparam int CW = 8;
    localparam int BW = 4*XW + FW + 3*AW + CW;
    localparam int KW = 320;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset, flush;
    always #5 clk = ~clk;

    logic          in_valid, in_ready, out_valid, out_ready;
    logic [XW-1:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic [XW-1:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
    logic [FW-1:0] in_funct, out_funct;
    logic [AW-1:0] in_rd, in_rs1, in_rs2, out_rd, out_rs1, out_rs2;
    logic [CW-1:0] in_ctrl, out_ctrl;
    skid_state_t   dbg_state;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0]   stall_cnt, bubble_cnt, flush_cnt;
`endif

    id_ex_pipe_reg dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_funct(in_funct), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_imm(out_imm), .out_funct(out_funct), .out_rd(out_rd), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_ctrl(out_ctrl),
`ifdef ID_EX_PERF_CNT_EN
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt),
`endif
        .dbg_state(dbg_state)
    );

    logic [BW-1:0] in_bus, out_bus;
    assign in_bus  = {in_pc, in_rs1_data, in_rs2_data, in_imm, in_funct,
                      in_rd, in_rs1, in_rs2, in_ctrl};
    assign out_bus = {out_pc, out_rs1_data, out_rs2_data, out_imm, out_funct,
                      out_rd, out_rs1, out_rs2, out_ctrl};

    // ---------------- checking ----------------
    int chk_cnt = 0;
    int err_cnt = 0;

    task automatic check_eq(input string tag, input logic [KW-1:0] act,
                            input logic [KW-1:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [BW-1:0] exp_q[$];

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0)
                    check_eq("spurious_out", {319'd0, out_valid}, '0);
                else
                    check_eq("sb_payload", {{(KW-BW){1'b0}}, out_bus},
                             {{(KW-BW){1'b0}}, exp_q.pop_front()});
            end
            if (flush)
                exp_q.delete();
            else if (in_valid && in_ready)
                exp_q.push_back(in_bus);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_in(input logic v, input logic [XW-1:0] pc,
                            input logic [CW-1:0] ctrl);
        in_valid    = v;
        in_pc       = pc;
        in_rs1_data = {$urandom, $urandom};
        in_rs2_data = {$urandom, $urandom};
        in_imm      = {$urandom, $urandom};
        in_funct    = FW'($urandom);
        in_rd       = AW'($urandom);
        in_rs1      = AW'($urandom);
        in_rs2      = AW'($urandom);
        in_ctrl     = ctrl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    ctrl_t c_rw_mw;
    logic  acc;

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive_in(1'b1, 64'h1234, 8'hff);

        // Reset held 2 cycles with in_valid high: nothing captured.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("rst_out_valid", out_valid, 1'b0);
            check_eq("rst_out_ctrl", out_ctrl, '0);
            check_eq("rst_in_ready", in_ready, 1'b1);
        end
        step();
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_eq("post_rst_valid", out_valid, 1'b0);
        check_eq("post_rst_pc", out_pc, '0);

        // Streaming PC 0,4,8 at full rate.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i < 3) drive_in(1'b1, 64'(i*4), 8'($urandom));
            else in_valid = 1'b0;
            @(negedge clk);
            check_eq("stream_in_ready", in_ready, 1'b1);
            if (i >= 1 && i <= 3) begin
                check_eq("stream_valid", out_valid, 1'b1);
                check_eq("stream_pc", out_pc, 64'((i-1)*4));
            end
        end

        // Backpressure: A, B, C with out_ready low.
        step();
        out_ready = 1'b0;
        drive_in(1'b1, 64'h100, 8'($urandom));
        step();
        drive_in(1'b1, 64'h104, 8'($urandom));
        @(negedge clk);
        check_eq("bp_a_pc", out_pc, 64'h100);
        check_eq("bp_rdy_one", in_ready, 1'b1);
        step();
        drive_in(1'b1, 64'h108, 8'($urandom));
        @(negedge clk);
        check_eq("bp_rdy_full", in_ready, 1'b0);
        check_eq("bp_state_full", dbg_state, ST_FULL);
        check_eq("bp_hold_pc", out_pc, 64'h100);
        step();
        @(negedge clk);
        check_eq("bp_rdy_hold", in_ready, 1'b0);
        check_eq("bp_hold_pc2", out_pc, 64'h100);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_still_a", out_pc, 64'h100);
        step();
        @(negedge clk);
        check_eq("bp_b_pc", out_pc, 64'h104);
        check_eq("bp_rdy_back", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("bp_c_pc", out_pc, 64'h108);
        step();
        @(negedge clk);
        check_eq("bp_empty", out_valid, 1'b0);

        // Flush while FULL with D offered.
        step();
        out_ready = 1'b0;
        drive_in(1'b1, 64'h200, 8'hff);
        step();
        drive_in(1'b1, 64'h204, 8'hff);
        step();
        drive_in(1'b1, 64'h300, 8'hff);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_eq("fl_valid", out_valid, 1'b0);
        check_eq("fl_ctrl", out_ctrl, '0);
        check_eq("fl_in_ready", in_ready, 1'b1);
        check_eq("fl_pc", out_pc, '0);
        out_ready = 1'b1;
        step();
        @(negedge clk);
        check_eq("fl_no_d", out_valid, 1'b0);

        // Flush in ONE: H drains in the flush cycle, I is dropped.
        step();
        out_ready = 1'b0;
        drive_in(1'b1, 64'h400, 8'($urandom));
        step();
        drive_in(1'b1, 64'h404, 8'($urandom));
        flush = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_eq("fl1_valid", out_valid, 1'b0);
        step();
        @(negedge clk);
        check_eq("fl1_no_i", out_valid, 1'b0);

        // Bubble gating of control bits.
        c_rw_mw = '0;
        c_rw_mw.reg_write = 1'b1;
        c_rw_mw.mem_write = 1'b1;
        step();
        out_ready = 1'b1;
        drive_in(1'b1, 64'h500, c_rw_mw);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("bub_valid", out_valid, 1'b1);
        check_eq("bub_ctrl_live", out_ctrl, c_rw_mw);
        step();
        @(negedge clk);
        check_eq("bub_invalid", out_valid, 1'b0);
        check_eq("bub_ctrl_zero", out_ctrl, '0);
        check_eq("bub_imm_zero", out_imm, '0);

        // Randomised traffic with occasional flushes.
        in_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            step();
            if (!in_valid || acc || flush)
                drive_in(1'($urandom_range(0, 1)), {$urandom, $urandom}, 8'($urandom));
            out_ready = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 15) == 0);
        end
        step();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (4) step();
        @(negedge clk);
        check_eq("rand_drained", 32'(exp_q.size()), '0);

        // Reset mid-stream discards held entries.
        step();
        out_ready = 1'b0;
        drive_in(1'b1, 64'h600, 8'hff);
        step();
        drive_in(1'b1, 64'h604, 8'hff);
        step();
        in_valid = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check_eq("mrst_valid", out_valid, 1'b0);
        check_eq("mrst_in_ready", in_ready, 1'b1);
        check_eq("mrst_state", dbg_state, ST_EMPTY);

`ifdef ID_EX_PERF_CNT_EN
        // 3 stall cycles, 2 flushes, then reset.
        step();
        reset = 1'b1;
        step();
        reset = 1'b0; out_ready = 1'b0;
        drive_in(1'b1, 64'h700, 8'($urandom));
        step();
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        flush = 1'b1; out_ready = 1'b1;
        step();
        step();
        flush = 1'b0;
        @(negedge clk);
        check_eq("perf_stall", stall_cnt, 32'd3);
        check_eq("perf_flush", flush_cnt, 32'd2);
        step();
        reset = 1'b1;
        @(negedge clk);
        check_eq("perf_rst_stall", stall_cnt, '0);
        check_eq("perf_rst_bubble", bubble_cnt, '0);
        check_eq("perf_rst_flush", flush_cnt, '0);
        step();
        reset = 1'b0;
`endif

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
